apb_requester: RTL and testbench

APB_REQUESTER -- requirements
Module: apb_requester

---
 rtl/apb_requester.sv | 120 ++++++++++++
 tb/tb_apb_requester.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_requester.sv
// APB requester: turns one user command into one APB transfer,
// with a wait-state timeout and a single-cycle completion pulse.
module apb_requester #(
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  input  logic              cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              cmd_ready,
  output logic              rsp_valid,
  output logic              rsp_err,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic              pready,
  input  logic [DATA_W-1:0] prdata
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] WMAX = CW'(TIMEOUT - 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [CW-1:0]     wait_q, wait_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

  // Next-state: capture in IDLE, fixed SETUP, wait/timeout in ACCESS
  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    unique case (1'b1)
      state_q == IDLE: begin
        if (cmd_valid) begin
          state_d  = SETUP;
          pwrite_d = ~cmd_op;
          paddr_d  = cmd_addr;
          pwdata_d = cmd_wdata;
        end
      end
      state_q == SETUP: begin
        state_d = ACCESS;
        wait_d  = '0;
      end
      state_q == ACCESS: begin
        if (pready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = pwrite_q ? '0 : prdata;
        end else if (wait_q == WMAX) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      wait_q      <= '0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign psel      = (state_q != IDLE);
  assign penable   = (state_q == ACCESS);
  assign pwrite    = pwrite_q;
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_apb_requester.sv
// Bench for apb_requester: transaction-level model compared every
// cycle, directed scenarios with literal expectations, random traffic.
module tb_apb_requester;

  localparam int AW = 4;
  localparam int DW = 32;
  localparam int TO = 128;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_op;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          cmd_ready;
  logic          rsp_valid;
  logic          rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic          psel;
  logic          penable;
  logic          pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic          pready;
  logic [DW-1:0] prdata;

  int total = 0;
  int bad   = 0;

  apb_requester #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .cmd_ready(cmd_ready),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err),
    .rsp_rdata(rsp_rdata),
    .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata),
    .pready(pready), .prdata(prdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h @%0t",
               nm, act, exp, $time);
    end
  endtask

  // Transaction-level model: a transfer is "busy" for k cycles after
  // acceptance; cycle 1 is setup, cycles 2.. are access cycles 1..
  logic          armed = 1'b0;
  logic          m_busy;
  int            m_k;
  logic          m_pw;
  logic [AW-1:0] m_pa;
  logic [DW-1:0] m_pd;
  logic          m_rv;
  logic          m_err;
  logic [DW-1:0] m_rd;

  always @(posedge clk) begin
    if (rst) begin
      armed  <= 1'b1;
      m_busy <= 1'b0;
      m_k    <= 0;
      m_pw   <= 1'b0;
      m_pa   <= '0;
      m_pd   <= '0;
      m_rv   <= 1'b0;
      m_err  <= 1'b0;
      m_rd   <= '0;
    end else begin
      m_rv <= 1'b0;
      if (!m_busy) begin
        if (cmd_valid) begin
          m_busy <= 1'b1;
          m_k    <= 1;
          m_pw   <= ~cmd_op;
          m_pa   <= cmd_addr;
          m_pd   <= cmd_wdata;
        end
      end else if (m_k == 1) begin
        m_k <= 2;
      end else if (pready) begin
        m_busy <= 1'b0;
        m_rv   <= 1'b1;
        m_err  <= 1'b0;
        m_rd   <= m_pw ? '0 : prdata;
      end else if (m_k - 1 == TO) begin
        m_busy <= 1'b0;
        m_rv   <= 1'b1;
        m_err  <= 1'b1;
        m_rd   <= '0;
      end else begin
        m_k <= m_k + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("cmd_ready", cmd_ready, !m_busy);
      chk("psel", psel, m_busy);
      chk("penable", penable, m_busy && m_k >= 2);
      chk("pwrite", pwrite, m_pw);
      chk("paddr", paddr, m_pa);
      chk("pwdata", pwdata, m_pd);
      chk("rsp_valid", rsp_valid, m_rv);
      chk("rsp_err", rsp_err, m_err);
      chk("rsp_rdata", rsp_rdata, m_rd);
    end
  end

  // One transfer from IDLE: pready rises on access cycle waits+1.
  task automatic run_cmd(input logic op,
                         input logic [AW-1:0] a,
                         input logic [DW-1:0] wd,
                         input int waits,
                         input logic [DW-1:0] rd,
                         input bit noise,
                         output int n_acc,
                         output logic err,
                         output logic [DW-1:0] rdat);
    int cyc;
    n_acc = 0;
    err   = 1'b0;
    rdat  = '0;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = a;
    cmd_wdata = wd;
    prdata    = rd;
    pready    = noise ? 1'($urandom) : 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (cyc = 0; cyc < 400; cyc++) begin
      if (noise) begin
        cmd_op    = 1'($urandom);
        cmd_addr  = AW'($urandom);
        cmd_wdata = $urandom;
      end
      if (rsp_valid) begin
        err  = rsp_err;
        rdat = rsp_rdata;
        break;
      end
      if (penable) begin
        n_acc++;
        pready = (n_acc > waits);
      end else begin
        pready = noise ? 1'($urandom) : 1'b0;
      end
      @(negedge clk);
    end
    if (cyc == 400) begin
      total++;
      bad++;
      $display("FAIL run_cmd: no rsp_valid within 400 cycles");
    end
    pready = 1'b0;
  endtask

  int            n;
  logic          e;
  logic [DW-1:0] r;
  logic [3:0]    ps;
  logic [3:0]    pe;

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    pready    = 1'b0;
    prdata    = '0;
    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1'b1);
    chk("rst_psel", psel, 1'b0);
    chk("rst_pwdata", pwdata, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    rst = 1'b0;
    @(negedge clk);

    // write, pready already high everywhere
    cmd_valid = 1'b1;
    cmd_op    = 1'b0;
    cmd_addr  = 4'h3;
    cmd_wdata = 32'hDEAD_BEEF;
    pready    = 1'b1;
    ps[3] = psel;
    pe[3] = penable;
    @(negedge clk);
    cmd_valid = 1'b0;
    ps[2] = psel;
    pe[2] = penable;
    chk("wr_pwrite", pwrite, 1'b1);
    chk("wr_paddr", paddr, 4'h3);
    @(negedge clk);
    ps[1] = psel;
    pe[1] = penable;
    chk("wr_pwdata", pwdata, 32'hDEAD_BEEF);
    @(negedge clk);
    ps[0] = psel;
    pe[0] = penable;
    chk("wr_rsp_valid", rsp_valid, 1'b1);
    chk("wr_rsp_err", rsp_err, 1'b0);
    chk("wr_rsp_rdata", rsp_rdata, 0);
    chk("wr_psel_seq", ps, 4'b0110);
    chk("wr_penable_seq", pe, 4'b0010);
    pready = 1'b0;
    @(negedge clk);
    chk("wr_pulse_one", rsp_valid, 1'b0);

    // read with five wait states
    run_cmd(1'b1, 4'hA, 32'h0, 5, 32'h1234_5678, 1'b0, n, e, r);
    chk("rd_n_access", n, 6);
    chk("rd_err", e, 1'b0);
    chk("rd_rdata", r, 32'h1234_5678);
    @(negedge clk);
    chk("rd_rdata_hold", rsp_rdata, 32'h1234_5678);

    // timeout
    run_cmd(1'b1, 4'h1, 32'h0, 100000, 32'h5555_AAAA, 1'b0, n, e, r);
    chk("to_n_access", n, TO);
    chk("to_err", e, 1'b1);
    chk("to_rdata", r, 0);
    chk("to_psel", psel, 1'b0);

    // pready on the last allowed access cycle wins
    run_cmd(1'b1, 4'h2, 32'h0, TO - 1, 32'h0BAD_F00D, 1'b0, n, e, r);
    chk("bd_n_access", n, TO);
    chk("bd_err", e, 1'b0);
    chk("bd_rdata", r, 32'h0BAD_F00D);
    @(negedge clk);

    // reset on access cycle 3
    cmd_valid = 1'b1;
    cmd_op    = 1'b1;
    cmd_addr  = 4'h7;
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
    for (int i = 0; i < 10 && n < 3; i++) begin
      @(negedge clk);
      if (penable) n++;
    end
    chk("rs_reached_acc3", n, 3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rs_psel", psel, 1'b0);
    chk("rs_rsp_valid", rsp_valid, 1'b0);
    chk("rs_cmd_ready", cmd_ready, 1'b1);
    @(negedge clk);
    chk("rs_no_late_rsp", rsp_valid, 1'b0);
    run_cmd(1'b1, 4'h2, 32'h0, 2, 32'h600D_CAFE, 1'b0, n, e, r);
    chk("rs_next_n", n, 3);
    chk("rs_next_err", e, 1'b0);
    chk("rs_next_rdata", r, 32'h600D_CAFE);

    // back-to-back with cmd_valid held
    cmd_valid = 1'b1;
    cmd_op    = 1'b0;
    cmd_addr  = 4'h5;
    cmd_wdata = 32'h1111_1111;
    pready    = 1'b1;
    prdata    = 32'hCAFE_0001;
    @(negedge clk);
    chk("bb_ready_setup", cmd_ready, 1'b0);
    cmd_op    = 1'b1;
    cmd_addr  = 4'h9;
    cmd_wdata = 32'h2222_2222;
    @(negedge clk);
    chk("bb_ready_access", cmd_ready, 1'b0);
    chk("bb_paddr_hold", paddr, 4'h5);
    chk("bb_pwdata_hold", pwdata, 32'h1111_1111);
    cmd_addr  = 4'h6;
    cmd_wdata = 32'h3333_3333;
    @(negedge clk);
    chk("bb_rsp1", rsp_valid, 1'b1);
    chk("bb_ready_rsp", cmd_ready, 1'b1);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("bb_second_setup", {psel, penable}, 2'b10);
    chk("bb_second_paddr", paddr, 4'h6);
    chk("bb_second_pwrite", pwrite, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("bb_rsp2", rsp_valid, 1'b1);
    chk("bb_rsp2_rdata", rsp_rdata, 32'hCAFE_0001);
    pready = 1'b0;

    // random traffic, model-checked every cycle
    for (int t = 0; t < 60; t++) begin
      int w;
      int sel;
      repeat ($urandom_range(0, 3)) begin
        cmd_valid = 1'b0;
        cmd_op    = 1'($urandom);
        cmd_addr  = AW'($urandom);
        pready    = 1'($urandom);
        @(negedge clk);
      end
      sel = $urandom_range(0, 19);
      if (sel < 17) w = $urandom_range(0, 8);
      else if (sel == 17) w = TO - 1;
      else if (sel == 18) w = TO - 2;
      else w = 1000;
      run_cmd(1'($urandom), AW'($urandom), $urandom, w,
              $urandom, 1'b1, n, e, r);
      chk("rnd_err", e, w >= TO);
    end

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
